// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan multiplexer.
// Holds the hex-to-segment patterns and the PWM sub-slot count.
package sseg_pkg;

  // PWM sub-slots per digit slot
  localparam int SUB_SLOTS = 16;

  // Active-high {g,f,e,d,c,b,a}; entry 15 first
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern, active-high.
// Ports: hex (4-bit nibble in), seg (7-bit {g,f,e,d,c,b,a} out).
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_PAT[hex];

endmodule

// File: rtl/sseg_scan_mux.sv
// Multiplexed seven-segment scanner with PWM brightness and tear-free
// frame-boundary updates.
// Ports: i_clk, i_rst (sync, active-high), i_data/i_dp/i_load (pending
// capture), i_bright (PWM level), o_an/o_seg/o_dp (registered drive),
// o_frame (scan-complete pulse).
// Optional: define SSEG_LZ_BLANK_EN to blank leading-zero digits.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic [3:0]              i_bright,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SUB_LEN = REFRESH_DIV / SUB_SLOTS;
  localparam int SW =
    (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

  localparam logic [IW-1:0] LAST_DIG =
    IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] LAST_SUB =
    SW'(SUB_LEN - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;

  // Prescaler split as sub_idx*SUB_LEN + sub_cnt
  logic [SW-1:0] sub_cnt;
  logic [3:0]    sub_idx;
  logic [IW-1:0] dig;
  logic [3:0]    b_q;

  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic sub_wrap;
  logic slot_wrap;
  logic frame_wrap;
  logic slot_start;

  assign sub_wrap   = (sub_cnt == LAST_SUB);
  assign slot_wrap  = sub_wrap && (sub_idx == 4'hF);
  assign frame_wrap = slot_wrap && (dig == LAST_DIG);
  assign slot_start = (sub_cnt == '0) &&
                      (sub_idx == 4'h0);

  // A reset cycle cancels the boundary, so keep the pulse quiet
  assign o_frame = frame_wrap && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sub_cnt <= '0;
      sub_idx <= '0;
      dig     <= '0;
      b_q     <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap)
        sub_idx <= sub_idx + 4'd1;
      if (slot_wrap)
        dig <= (dig == LAST_DIG) ? '0 : dig + 1'b1;
      if (slot_start)
        b_q <= i_bright;
    end
  end

  // A load landing on the boundary bypasses pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (i_load) begin
        pend_data <= i_data;
        pend_dp   <= i_dp;
      end
      if (frame_wrap) begin
        act_data <= i_load ? i_data : pend_data;
        act_dp   <= i_load ? i_dp   : pend_dp;
      end
    end
  end

  logic [3:0]            nib;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] an_hot;

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    an_hot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig == IW'(k)) begin
        nib       = act_data[4*k +: 4];
        dp_sel    = act_dp[k];
        an_hot[k] = 1'b1;
      end
    end
  end

  logic [6:0] seg_pat;

  sseg_hex_decoder u_dec (
    .hex (nib),
    .seg (seg_pat)
  );

  logic show;

`ifdef SSEG_LZ_BLANK_EN
  // Highest non-zero nibble; digit 0 is always shown
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (act_data[4*k +: 4] != 4'h0)
        msd = IW'(k);
    end
  end

  assign show = (dig <= msd);
`else
  assign show = 1'b1;
`endif

  logic pwm_on;
  logic an_on;

  assign pwm_on = (sub_idx <= b_q);
  assign an_on  = pwm_on && show;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an  <= AN_OFF;
      o_seg <= SEG_OFF;
      o_dp  <= DP_OFF;
    end else begin
      o_an  <= (an_on ? an_hot : '0) ^ AN_OFF;
      o_seg <= seg_pat ^ SEG_OFF;
      o_dp  <= dp_sel ^ DP_OFF;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux: 4 digits, 16-cycle slots,
// active-low anodes and segments.
module tb_sseg_scan_mux;

`ifdef SSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dpi;
  logic        load;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  always #5 clk = ~clk;

  sseg_scan_mux #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (16),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data),
    .i_dp     (dpi),
    .i_load   (load),
    .i_bright (bright),
    .o_an     (an),
    .o_seg    (seg),
    .o_dp     (dp),
    .o_frame  (frame)
  );

  // One record per observed output slot (16 cycles)
  typedef struct {
    bit          ld;
    logic [15:0] d;
    logic [3:0]  dpi;
    logic [3:0]  br;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          on;
    bit          lz;
  } vec_t;

  vec_t tbl [24];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input bit ld, input logic [15:0] d,
    input logic [3:0] dpi, input logic [3:0] br,
    input logic [3:0] an, input logic [6:0] seg,
    input logic dp, input int on, input bit lz);
    vec_t v;
    v.ld = ld; v.d = d; v.dpi = dpi; v.br = br;
    v.an = an; v.seg = seg; v.dp = dp;
    v.on = on; v.lz = lz;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, got, want);
    end
  endtask

  task automatic wait_frame(input string name);
    int k;
    k = 0;
    while (frame !== 1'b1 && k < 200) begin
      step;
      k++;
    end
    chk(name, {15'd0, frame}, 16'd1);
  endtask

  int         exp_on;
  int         an_bad, seg_bad, dp_bad, fr_bad;
  logic [3:0] exp_an;
  logic       exp_fr;
  int         cnt_on;

  initial begin
    // F1: active=0, pending gets 0146
    tbl[0]  = mk(1, 16'h0146, 4'h0, 4'hF, 4'hE, 7'h40, 1, 16, 0);
    tbl[1]  = mk(0, 16'h0, 4'h0, 4'hF, 4'hD, 7'h40, 1, 16, 1);
    tbl[2]  = mk(0, 16'h0, 4'h0, 4'hF, 4'hB, 7'h40, 1, 16, 1);
    tbl[3]  = mk(0, 16'h0, 4'h0, 4'hF, 4'h7, 7'h40, 1, 16, 1);
    // F2: 0146
    tbl[4]  = mk(0, 16'h0, 4'h0, 4'hF, 4'hE, 7'h02, 1, 16, 0);
    tbl[5]  = mk(0, 16'h0, 4'h0, 4'hF, 4'hD, 7'h19, 1, 16, 0);
    tbl[6]  = mk(0, 16'h0, 4'h0, 4'hF, 4'hB, 7'h79, 1, 16, 0);
    tbl[7]  = mk(0, 16'h0, 4'h0, 4'hF, 4'h7, 7'h40, 1, 16, 1);
    // F3: mid-frame load 4166, display unchanged
    tbl[8]  = mk(0, 16'h0, 4'h0, 4'hF, 4'hE, 7'h02, 1, 16, 0);
    tbl[9]  = mk(1, 16'h4166, 4'h0, 4'hF, 4'hD, 7'h19, 1, 16, 0);
    tbl[10] = mk(0, 16'h0, 4'h0, 4'hF, 4'hB, 7'h79, 1, 16, 0);
    tbl[11] = mk(0, 16'h0, 4'h0, 4'hF, 4'h7, 7'h40, 1, 16, 1);
    // F4: 4166; two loads, last (004A) wins
    tbl[12] = mk(1, 16'h1234, 4'h1, 4'hF, 4'hE, 7'h02, 1, 16, 0);
    tbl[13] = mk(1, 16'h004A, 4'h2, 4'hF, 4'hD, 7'h02, 1, 16, 0);
    tbl[14] = mk(0, 16'h0, 4'h0, 4'hF, 4'hB, 7'h79, 1, 16, 0);
    tbl[15] = mk(0, 16'h0, 4'h0, 4'hF, 4'h7, 7'h19, 1, 16, 0);
    // F5: 004A, dp on digit 1, bright 3
    tbl[16] = mk(0, 16'h0, 4'h0, 4'h3, 4'hE, 7'h08, 1, 4, 0);
    tbl[17] = mk(0, 16'h0, 4'h0, 4'h3, 4'hD, 7'h19, 0, 4, 0);
    tbl[18] = mk(0, 16'h0, 4'h0, 4'h3, 4'hB, 7'h40, 1, 4, 1);
    tbl[19] = mk(0, 16'h0, 4'h0, 4'h3, 4'h7, 7'h40, 1, 4, 1);
    // F6: bright 0 -> one cycle per slot
    tbl[20] = mk(0, 16'h0, 4'h0, 4'h0, 4'hE, 7'h08, 1, 1, 0);
    tbl[21] = mk(0, 16'h0, 4'h0, 4'h0, 4'hD, 7'h19, 0, 1, 0);
    tbl[22] = mk(0, 16'h0, 4'h0, 4'h0, 4'hB, 7'h40, 1, 1, 1);
    tbl[23] = mk(0, 16'h0, 4'h0, 4'h0, 4'h7, 7'h40, 1, 1, 1);

    rst    = 1'b1;
    data   = '0;
    dpi    = '0;
    load   = 1'b0;
    bright = tbl[0].br;
    repeat (3) step;
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {9'd0, seg}, 16'h007F);
    chk("rst_dp", {15'd0, dp}, 16'h0001);
    chk("rst_frame", {15'd0, frame}, 16'h0000);

    rst = 1'b0;
    step;

    for (int n = 0; n < 24; n++) begin
      exp_on  = (LZ && tbl[n].lz) ? 0 : tbl[n].on;
      an_bad  = 0;
      seg_bad = 0;
      dp_bad  = 0;
      fr_bad  = 0;
      for (int i = 0; i < 16; i++) begin
        if (i == 0 && tbl[n].ld) begin
          load = 1'b1;
          data = tbl[n].d;
          dpi  = tbl[n].dpi;
        end
        exp_an = (i < exp_on) ? tbl[n].an : 4'hF;
        if (an !== exp_an) an_bad++;
        if (i < exp_on && seg !== tbl[n].seg)
          seg_bad++;
        if (i < exp_on && dp !== tbl[n].dp)
          dp_bad++;
        exp_fr = (tbl[n].an == 4'h7) && (i == 14);
        if (frame !== exp_fr) fr_bad++;
        if (i == 15 && n < 23)
          bright = tbl[n+1].br;
        step;
        load = 1'b0;
      end
      chk($sformatf("slot%0d_an_badcyc", n),
          16'(an_bad), 16'd0);
      chk($sformatf("slot%0d_seg_badcyc", n),
          16'(seg_bad), 16'd0);
      chk($sformatf("slot%0d_dp_badcyc", n),
          16'(dp_bad), 16'd0);
      chk($sformatf("slot%0d_frame_badcyc", n),
          16'(fr_bad), 16'd0);
    end

    // Load coincident with the frame boundary
    bright = 4'hF;
    wait_frame("frame_wait_a");
    load = 1'b1;
    data = 16'h2345;
    dpi  = 4'h0;
    step;
    load = 1'b0;
    step;
    chk("bypass_an", {12'd0, an}, 16'h000E);
    chk("bypass_seg", {9'd0, seg}, 16'h0012);

    // Reset in the middle of the digit 2 slot
    repeat (37) step;
    chk("dig2_an", {12'd0, an}, 16'h000B);
    rst = 1'b1;
    step;
    chk("midrst_an", {12'd0, an}, 16'h000F);
    chk("midrst_frame", {15'd0, frame}, 16'h0000);
    chk("midrst_seg", {9'd0, seg}, 16'h007F);
    rst = 1'b0;
    step;
    cnt_on = 0;
    for (int i = 0; i < 16; i++) begin
      if (an === 4'hE && seg === 7'h40) cnt_on++;
      step;
    end
    chk("postrst_d0_cycles", 16'(cnt_on), 16'd16);
    chk("postrst_d1_an", {12'd0, an},
        LZ ? 16'h000F : 16'h000D);

    // Pending was cleared, so digit 0 still shows 0
    wait_frame("frame_wait_b");
    step;
    step;
    chk("postrst_frame_an", {12'd0, an}, 16'h000E);
    chk("postrst_frame_seg", {9'd0, seg}, 16'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; SHALL be a multiple of 16 and at least 16.
REQ-003 Parameter AN_ACTIVE_LOW, default 1, anode polarity (1 = anode on when driven 0).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1, segment and dp polarity (1 = segment lit when driven 0).
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_rst  input  1  reset, synchronous and active-high.
REQ-007 i_data  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-008 i_dp  input  NUM_DIGITS  decimal point request per digit.
REQ-009 i_load  input  1  one-cycle strobe capturing i_data/i_dp into pending register.
REQ-010 i_bright  input  4  brightness, sampled at each slot start.
REQ-011 o_an  output  NUM_DIGITS  anode enables, registered.
REQ-012 o_seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-013 o_dp  output  1  decimal point, registered.
REQ-014 o_frame  output  1  one-cycle pulse when a full scan of all digits completes.

Function
REQ-015 Prescaler counts 0..REFRESH_DIV-1 then wraps; on wrap digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-016 o_frame SHALL pulse in the cycle the digit index wraps NUM_DIGITS-1 -> 0.
REQ-017 Each slot = 16 sub-slots of REFRESH_DIV/16 cycles; anode of current digit asserted during sub-slots 0..B, B = i_bright sampled at slot start (B=15 full on, B=0 is 1/16 duty).
REQ-018 Exactly one anode active at any time, or none during PWM off-time/blanking; never two.
REQ-019 i_load SHALL capture into pending register; pending copied into active display register at frame boundary only (tear-free update).
REQ-020 i_load coincident with frame boundary: i_data/i_dp go directly to active register in that cycle.
REQ-021 Multiple i_load within one frame: last one wins.
REQ-022 Hex decode 0-F to standard seven-segment patterns (0=3F, 1=06, ... A=77, b=7C, C=39, d=5E, E=79, F=71, active-high form) before polarity inversion.
REQ-023 Output latency: o_an/o_seg/o_dp reflect internal digit index and PWM state one cycle later.

Reset
REQ-024 While i_rst high at clock edge: prescaler=0, digit index=0, pending and active registers=0, o_an all inactive, o_seg and o_dp unlit, o_frame=0.
REQ-025 Reset mid-scan SHALL abort current slot; first post-reset slot is digit 0 with full REFRESH_DIV length.
REQ-026 Active register after reset displays 0 until first frame boundary following an i_load.

Configuration
REQ-027 Macro SSEG_LZ_BLANK_EN defined: digits above the most significant non-zero active nibble SHALL keep anode inactive for their whole slot; digit 0 always shown; slot timing unchanged.
REQ-028 Macro undefined: all NUM_DIGITS digits displayed, no blanking logic present.

Structure
REQ-029 Package sseg_pkg SHALL hold the 16-entry segment pattern constants and sub-slot count constant (16).
REQ-030 Sub-module sseg_hex_decoder (4-bit in, 7-bit active-high out, combinational) SHALL be instantiated once.

Verification
REQ-031 Bench SHALL use NUM_DIGITS=4, REFRESH_DIV=16, active-low polarity.
REQ-032 Reset, load 16'h0146, bright=15 -> after first frame o_an cycles 1110,1101,1011,0111 each 16 cycles; o_seg = 0x40^7F... i.e. inverted 3F? no: digits 6,4,1,0 show ~7D,~66,~06,~3F.
REQ-033 Load 16'h4166 mid-frame -> display unchanged until o_frame, then new digits from next slot 0.
REQ-034 bright=3 -> each anode low exactly 4 cycles of its 16-cycle slot, high 12.
REQ-035 SSEG_LZ_BLANK_EN, load 16'h004A -> digits 3,2 anodes stay high all slot; digits 1,0 show 4 and A.
REQ-036 Assert i_rst during digit 2 slot -> next edge all anodes inactive, o_frame 0; after release digit 0 shown for 16 cycles.
